// File: rtl/sha_uart_pkg.sv
// rtl/sha_uart_pkg.sv - shared types and protocol constants for the SHA-1 UART link
//
// Purpose: host state encoding and fixed block/digest sizes of the UART SHA-1 protocol.
// Ports:   none (package).
package sha_uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } host_state_e;

  localparam int BLOCK_BYTES  = 64;
  localparam int DIGEST_BYTES = 20;
  localparam int BLOCK_BITS   = 512;
  localparam int DIGEST_BITS  = 160;

endpackage

// File: rtl/sha_uart_host_timer.sv
// rtl/sha_uart_host_timer.sv - saturating cycle counter with clear, enable and expiry flag
//
// Purpose: counts enabled cycles since the last clear; flags when LIMIT-1 is reached.
// Ports:   clk, rst (sync, active-high)
//          i_clear   - zero the count (wins over enable)
//          i_enable  - count this cycle
//          o_expired - count equals LIMIT-1
module sha_uart_host_timer #(
  parameter int LIMIT = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with a valid/ready byte output
//
// Purpose: samples each bit at its centre, LSB first; drops bytes with a bad stop bit.
//          One bit lasts prescale*8 clk cycles.
// Ports:   clk, rst (sync, active-high)
//          m_axis_tdata/tvalid/tready - byte output
//          rxd                        - serial input
//          prescale                   - bit time divider
module uart_rx (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        rxd,
  input  logic [15:0] prescale
);

  logic [18:0] r_cnt;
  logic [3:0]  r_bits;
  logic [7:0]  r_data;
  logic [1:0]  r_sync;
  logic        r_tvalid;
  logic [7:0]  r_tdata;
  logic        w_rxd;

  assign w_rxd         = r_sync[1];
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_bits   <= '0;
      r_data   <= '0;
      r_sync   <= 2'b11;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
    end else begin
      r_sync <= {r_sync[0], rxd};
      if (r_tvalid && m_axis_tready) r_tvalid <= 1'b0;
      if (r_cnt != 19'd0) begin
        r_cnt <= r_cnt - 19'd1;
      end else if (r_bits == 4'd0) begin
        // half a bit from the falling edge lands in the middle of the start bit
        if (!w_rxd) begin
          r_cnt  <= {1'b0, prescale, 2'b00} - 19'd1;
          r_bits <= 4'd10;
        end
      end else if (r_bits == 4'd10) begin
        if (!w_rxd) begin
          r_bits <= 4'd9;
          r_cnt  <= {prescale, 3'b000} - 19'd1;
        end else begin
          r_bits <= 4'd0;
        end
      end else if (r_bits > 4'd1) begin
        r_data <= {w_rxd, r_data[7:1]};
        r_bits <= r_bits - 4'd1;
        r_cnt  <= {prescale, 3'b000} - 19'd1;
      end else begin
        r_bits <= 4'd0;
        if (w_rxd) begin
          r_tdata  <= r_data;
          r_tvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a valid/ready byte input
//
// Purpose: serialises one byte per handshake, LSB first, one stop bit.
//          One bit lasts prescale*8 clk cycles.
// Ports:   clk, rst (sync, active-high)
//          s_axis_tdata/tvalid/tready - byte input
//          txd                        - serial output, idles high
//          prescale                   - bit time divider
module uart_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        txd,
  input  logic [15:0] prescale
);

  logic [18:0] r_cnt;
  logic [3:0]  r_bits;
  logic [8:0]  r_data;
  logic        r_txd;
  logic [18:0] w_bit_time;

  assign w_bit_time    = {prescale, 3'b000} - 19'd1;
  assign s_axis_tready = (r_bits == 4'd0) && (r_cnt == 19'd0);
  assign txd           = r_txd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_bits <= '0;
      r_data <= '0;
      r_txd  <= 1'b1;
    end else if (r_cnt != 19'd0) begin
      r_cnt <= r_cnt - 19'd1;
    end else if (r_bits == 4'd0) begin
      if (s_axis_tvalid) begin
        r_txd  <= 1'b0;
        r_data <= {1'b1, s_axis_tdata};
        r_bits <= 4'd9;
        r_cnt  <= w_bit_time;
      end
    end else begin
      // eight data bits then the stop bit held in r_data[8]
      r_txd  <= r_data[0];
      r_data <= {1'b0, r_data[8:1]};
      r_bits <= r_bits - 4'd1;
      r_cnt  <= w_bit_time;
    end
  end

endmodule

// File: rtl/sha_uart_host.sv
// rtl/sha_uart_host.sv - host initiator for the UART SHA-1 accelerator
//
// Purpose: takes a 512-bit block, sends it as 64 UART bytes MSB byte first, collects the
//          20-byte digest and returns it as 160 bits; aborts with rsp_error on timeout.
// Ports:   clk, rst (sync, active-high), prescale - UART bit time divider
//          rxd/txd                               - serial link to the accelerator
//          req_valid/req_ready/req_block         - block request
//          rsp_valid/rsp_ready/rsp_digest/rsp_error - digest response
//          busy                                  - not idle
module sha_uart_host
  import sha_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            prescale,
  input  logic                   rxd,
  output logic                   txd,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [BLOCK_BITS-1:0]  req_block,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DIGEST_BITS-1:0] rsp_digest,
  output logic                   rsp_error,
  output logic                   busy
);

  host_state_e             r_state;
  host_state_e             w_state_nxt;
  logic [BLOCK_BITS-1:0]   r_blk;
  logic [DIGEST_BITS-1:0]  r_digest;
  logic [6:0]              r_cnt;
  logic                    r_rsp_error;

  logic                    w_tx_tvalid;
  logic                    w_tx_tready;
  logic [7:0]              w_tx_tdata;
  logic                    w_rx_tvalid;
  logic [7:0]              w_rx_tdata;
  logic                    w_timer_clear;
  logic                    w_timer_expired;
  logic                    w_tx_last;
  logic                    w_rx_last;

  assign w_tx_tvalid = (r_state == SEND);
  assign w_tx_tdata  = r_blk[BLOCK_BITS-1-8*int'(r_cnt) -: 8];
  assign w_tx_last   = w_tx_tready && (r_cnt == 7'(BLOCK_BYTES - 1));
  assign w_rx_last   = w_rx_tvalid && (r_cnt == 7'(DIGEST_BYTES - 1));

  uart_tx u_uart_tx (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (w_tx_tdata),
    .s_axis_tvalid (w_tx_tvalid),
    .s_axis_tready (w_tx_tready),
    .txd           (txd),
    .prescale      (prescale)
  );

  uart_rx u_uart_rx (
    .clk           (clk),
    .rst           (rst),
    .m_axis_tdata  (w_rx_tdata),
    .m_axis_tvalid (w_rx_tvalid),
    .m_axis_tready (1'b1),
    .rxd           (rxd),
    .prescale      (prescale)
  );

  // held at zero outside RECV, restarted by every digest byte
  assign w_timer_clear = (r_state != RECV) || w_rx_tvalid;

  sha_uart_host_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_timer_clear),
    .i_enable  (r_state == RECV),
    .o_expired (w_timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (req_valid) w_state_nxt = SEND;
      SEND: if (w_tx_last) w_state_nxt = RECV;
      // a byte arriving in the expiry cycle beats the timeout
      RECV: if (w_rx_last || (!w_rx_tvalid && w_timer_expired)) w_state_nxt = DONE;
      DONE: if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk       <= '0;
      r_digest    <= '0;
      r_cnt       <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_blk <= req_block;
            r_cnt <= '0;
          end
        end
        SEND: begin
          if (w_tx_last) begin
            r_cnt    <= '0;
            r_digest <= '0;
          end else if (w_tx_tready) begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        RECV: begin
          if (w_rx_tvalid) begin
            r_digest[DIGEST_BITS-1-8*int'(r_cnt) -: 8] <= w_rx_tdata;
            r_cnt <= r_cnt + 7'd1;
            if (w_rx_last) r_rsp_error <= 1'b0;
          end else if (w_timer_expired) begin
            r_rsp_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign rsp_valid  = (r_state == DONE);
  assign rsp_digest = r_digest;
  assign rsp_error  = r_rsp_error;
  assign busy       = (r_state != IDLE);

endmodule
